watch_time_core: RTL and testbench

Timekeeping core for the FPGA watch. Consumes the slow divided clock produced by the clock divider, synchronises it into the system clock domain, converts each rising edge into a one-cycle tick, and counts ticks into hours/minutes/seconds. It also accepts a time-set request through a valid/ready handshake. Display and button logic sit downstream and upstream of it.

---
 rtl/watch_time_core_if.sv | 12 +
 rtl/watch_time_core.sv | 92 +++++++++
 tb/tb_watch_time_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/watch_time_core_if.sv
// watch_time_core_if: time-set valid/ready request channel with its rejection pulse
//   master drives set_valid/set_hour/set_min/set_sec; slave answers set_ready/set_err
interface watch_time_core_if;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_err;
  modport master (output set_valid, set_hour, set_min, set_sec, input set_ready, set_err);
  modport slave  (input set_valid, set_hour, set_min, set_sec, output set_ready, set_err);
endinterface

// File: rtl/watch_time_core.sv
// watch_time_core: synchronises the divided clock into ticks and counts them into hh:mm:ss
//   clk, rst (async active-low), clk_div_in (async divided clock), run (count enable level),
//   clear (sync zeroing), set_if (time-set handshake, set_err on out-of-range request),
//   hour/min/sec (current time), sec_pulse/day_pulse (one-cycle increment/midnight pulses)
module watch_time_core #(
  parameter int TICKS_PER_SEC = 100,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  input  logic             run,
  input  logic             clear,
  watch_time_core_if.slave set_if,
  output logic [4:0]       hour,
  output logic [5:0]       min,
  output logic [5:0]       sec,
  output logic             sec_pulse,
  output logic             day_pulse
);
  localparam int FW = $clog2(TICKS_PER_SEC);
  typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;
  state_t state, state_n;
  logic s1, s2, prev, tick;
  logic [FW-1:0] frac;
  logic [4:0] ld_hour;
  logic [5:0] ld_min, ld_sec;
  logic accept, in_range, count, last_frac, sec_wrap, min_wrap, hour_wrap;
  always_comb begin
    accept           = set_if.set_valid & set_if.set_ready;
    state_n          = accept ? LOAD : (run ? RUN : STOP);
    in_range         = ({1'b0, ld_hour} < 6'(HOURS_PER_DAY)) && (ld_min < 6'd60) && (ld_sec < 6'd60);
    set_if.set_err   = (state == LOAD) && !in_range;
    count            = (state == RUN) && tick && !clear;
    last_frac        = frac == FW'(TICKS_PER_SEC - 1);
    sec_wrap         = sec == 6'd59;
    min_wrap         = min == 6'd59;
    hour_wrap        = hour == 5'(HOURS_PER_DAY - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= STOP;
    else      state <= state_n;
  // tick is registered after the edge detector, giving a 4-cycle edge-to-display latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1, s2, prev, tick} <= '0;
      frac                 <= '0;
      hour                 <= '0;
      min                  <= '0;
      sec                  <= '0;
      ld_hour              <= '0;
      ld_min               <= '0;
      ld_sec               <= '0;
      set_if.set_ready     <= 1'b0;
      sec_pulse            <= 1'b0;
      day_pulse            <= 1'b0;
    end else begin
      s1               <= clk_div_in;
      s2               <= s1;
      prev             <= s2;
      tick             <= s2 & ~prev;
      set_if.set_ready <= state_n != LOAD;
      sec_pulse        <= count && last_frac;
      day_pulse        <= count && last_frac && sec_wrap && min_wrap && hour_wrap;
      if (accept) begin
        ld_hour <= set_if.set_hour;
        ld_min  <= set_if.set_min;
        ld_sec  <= set_if.set_sec;
      end
      if (clear) begin
        {hour, min, sec} <= '0;
        frac             <= '0;
      end else if (state == LOAD) begin
        if (in_range) begin
          hour <= ld_hour;
          min  <= ld_min;
          sec  <= ld_sec;
          frac <= '0;
        end
      end else if (count) begin
        frac <= last_frac ? '0 : frac + 1'b1;
        if (last_frac) begin
          sec <= sec_wrap ? '0 : sec + 6'd1;
          if (sec_wrap) begin
            min <= min_wrap ? '0 : min + 6'd1;
            if (min_wrap) hour <= hour_wrap ? '0 : hour + 5'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_watch_time_core.sv
// tb_watch_time_core: directed plus randomized checks of watch_time_core against a seconds-of-day model
module tb_watch_time_core;
  localparam int TPS = 4;
  localparam int HPD = 24;
  localparam int DAY = HPD * 3600;
  logic clk, rst, clk_div_in, run, clear;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic sec_pulse, day_pulse;
  watch_time_core_if sif();
  watch_time_core #(.TICKS_PER_SEC(TPS), .HOURS_PER_DAY(HPD)) dut (
    .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .run(run), .clear(clear),
    .set_if(sif), .hour(hour), .min(min), .sec(sec),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse)
  );
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // reference model: time as seconds-of-day, mode 0=stopped 1=running 2=loading,
  // a tick lands on the 4th clock edge counting from the one that first sees clk_div_in high
  int tod, frac, mode, m_ready, m_sp, m_day, lh, lm, ls;
  bit [3:0] hist;
  bit tk, acc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tod = 0; frac = 0; mode = 0; m_ready = 0; m_sp = 0; m_day = 0; hist = '0;
    end else begin
      tk  = hist[2] & ~hist[3];
      acc = sif.set_valid && (m_ready != 0);
      m_sp = 0;
      m_day = 0;
      if (clear) begin
        tod = 0;
        frac = 0;
      end else if (mode == 2) begin
        if (lh < HPD && lm < 60 && ls < 60) begin
          tod = lh * 3600 + lm * 60 + ls;
          frac = 0;
        end
      end else if (mode == 1 && tk) begin
        frac++;
        if (frac == TPS) begin
          frac = 0;
          tod = (tod + 1) % DAY;
          m_sp = 1;
          m_day = (tod == 0) ? 1 : 0;
        end
      end
      if (acc) begin
        lh = int'(sif.set_hour);
        lm = int'(sif.set_min);
        ls = int'(sif.set_sec);
      end
      mode = acc ? 2 : (run ? 1 : 0);
      m_ready = (mode != 2) ? 1 : 0;
      hist = {hist[2:0], clk_div_in};
    end
  end
  int n_sp = 0, n_day = 0, n_err = 0;
  always @(negedge clk) begin
    if (sec_pulse) n_sp++;
    if (day_pulse) n_day++;
    if (sif.set_err) n_err++;
    if (rst) begin
      check("hour", int'(hour), tod / 3600);
      check("min", int'(min), (tod / 60) % 60);
      check("sec", int'(sec), tod % 60);
      check("sec_pulse", int'(sec_pulse), m_sp);
      check("day_pulse", int'(day_pulse), m_day);
      check("set_ready", int'(sif.set_ready), m_ready);
      check("set_err", int'(sif.set_err), (mode == 2 && !(lh < HPD && lm < 60 && ls < 60)) ? 1 : 0);
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic div_edge(input int hi, input int lo);
    clk_div_in = 1;
    cycles(hi);
    clk_div_in = 0;
    cycles(lo);
  endtask
  task automatic edges(input int n);
    repeat (n) div_edge(2, 2);
  endtask
  task automatic set_time(input int h, input int m, input int s);
    sif.set_valid = 1;
    sif.set_hour  = 5'(h);
    sif.set_min   = 6'(m);
    sif.set_sec   = 6'(s);
    cycles(1);
    sif.set_valid = 0;
    cycles(1);
  endtask
  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, int'(hour), h);
    check({tag, "_min"}, int'(min), m);
    check({tag, "_sec"}, int'(sec), s);
  endtask
  int b_sp, b_day, b_err, r;
  initial begin
    rst = 0; clk_div_in = 0; run = 0; clear = 0;
    sif.set_valid = 0; sif.set_hour = 0; sif.set_min = 0; sif.set_sec = 0;
    cycles(3);
    check_time("reset", 0, 0, 0);
    check("reset_ready", int'(sif.set_ready), 0);
    check("reset_pulses", int'(sec_pulse) + int'(day_pulse) + int'(sif.set_err), 0);
    rst = 1;
    cycles(2);
    run = 1;
    cycles(2);
    b_sp = n_sp;
    edges(8);
    cycles(4);
    check("count_sec", int'(sec), 2);
    check("count_pulses", n_sp - b_sp, 2);
    b_sp = n_sp;
    b_day = n_day;
    set_time(23, 59, 58);
    check_time("load", 23, 59, 58);
    edges(8);
    cycles(4);
    check_time("midnight", 0, 0, 0);
    check("midnight_day", n_day - b_day, 1);
    check("midnight_sp", n_sp - b_sp, 2);
    b_err = n_err;
    set_time(12, 60, 0);
    check("bad_set_err", n_err - b_err, 1);
    check_time("bad_set", 0, 0, 0);
    edges(2);
    run = 0;
    cycles(1);
    edges(10);
    run = 1;
    cycles(1);
    edges(2);
    cycles(4);
    check("pause_sec", int'(sec), 1);
    set_time(5, 10, 30);
    edges(3);
    b_sp = n_sp;
    clk_div_in = 1;
    cycles(2);
    clk_div_in = 0;
    cycles(1);
    clear = 1;
    cycles(1);
    clear = 0;
    cycles(3);
    check_time("clear_tick", 0, 0, 0);
    check("clear_tick_sp", n_sp - b_sp, 0);
    sif.set_valid = 1; sif.set_hour = 12; sif.set_min = 0; sif.set_sec = 0;
    cycles(1);
    sif.set_valid = 0;
    clear = 1;
    cycles(1);
    clear = 0;
    cycles(2);
    check_time("clear_load", 0, 0, 0);
    set_time(5, 10, 30);
    edges(2);
    @(posedge clk);
    #3 rst = 0;
    sif.set_valid = 1; sif.set_hour = 7; sif.set_min = 7; sif.set_sec = 7;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst_ready", int'(sif.set_ready), 0);
    check("async_rst_pulses", int'(sec_pulse) + int'(day_pulse) + int'(sif.set_err), 0);
    cycles(2);
    rst = 1;
    #1 check("rel_ready", int'(sif.set_ready), 0);
    cycles(1);
    sif.set_valid = 0;
    cycles(2);
    check_time("rel_discard", 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4) div_edge(int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
      else if (r == 5) begin run = 1'($urandom); cycles(1); end
      else if (r == 6) set_time(int'($urandom_range(0, 25)), int'($urandom_range(0, 62)), int'($urandom_range(0, 62)));
      else if (r == 7) begin clear = 1; cycles(1); clear = 0; end
      else if (r == 8) cycles(int'($urandom_range(1, 3)));
      else set_time(23, 59, int'($urandom_range(55, 59)));
    end
    cycles(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
